// File: rtl/bitty_sequencer.sv
// Multi-cycle control sequencer for the Bitty core: fetches, latches, dispatches
// to the ALU (non-branch only) and retires each instruction with a PC enable pulse.
module bitty_sequencer #(
  parameter int AW     = 8,
  parameter int IW     = 16,
  parameter int WD_MAX = 255
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          run,
  input  logic [AW-1:0] pc_in,
  output logic [AW-1:0] mem_addr,
  output logic          mem_rd,
  input  logic [IW-1:0] mem_data,
  output logic [IW-1:0] instruction,
  output logic          alu_start,
  input  logic          alu_done,
  input  logic [IW-1:0] alu_result,
  output logic [IW-1:0] last_alu_result,
  output logic          en_pc,
  output logic          busy,
  output logic          err,
  output logic [15:0]   instr_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LATCH,
    S_EXEC,
    S_WAIT,
    S_UPDATE
  } state_t;

  // The watchdog holds the number of WAIT cycles already spent without alu_done,
  // so it reads WD_MAX-1 during the last cycle the ALU is allowed to finish in.
  localparam logic [7:0] WD_LAST = 8'(WD_MAX - 1);

  state_t     state;
  state_t     state_next;
  logic [7:0] watchdog;
  logic       wd_expire;

  assign mem_addr = pc_in;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    mem_rd     = 1'b0;
    alu_start  = 1'b0;
    en_pc      = 1'b0;
    busy       = 1'b1;
    wd_expire  = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (run && !err) begin
          state_next = S_FETCH;
        end
      end
      S_FETCH: begin
        mem_rd     = 1'b1;
        state_next = S_LATCH;
      end
      S_LATCH: begin
        if (mem_data[1:0] == 2'b10) begin
          state_next = S_UPDATE;
        end else begin
          state_next = S_EXEC;
        end
      end
      S_EXEC: begin
        alu_start  = 1'b1;
        state_next = S_WAIT;
      end
      S_WAIT: begin
        // A completion on the limit cycle takes priority over the timeout.
        if (alu_done) begin
          state_next = S_UPDATE;
        end else if (watchdog == WD_LAST) begin
          wd_expire  = 1'b1;
          state_next = S_IDLE;
        end
      end
      S_UPDATE: begin
        en_pc      = 1'b1;
        state_next = run ? S_FETCH : S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instruction     <= '0;
      last_alu_result <= '0;
      watchdog        <= '0;
      err             <= 1'b0;
      instr_count     <= '0;
    end else begin
      if (state == S_LATCH) begin
        instruction <= mem_data;
      end
      if (state == S_EXEC) begin
        watchdog <= '0;
      end else if (state == S_WAIT && !alu_done && !wd_expire) begin
        watchdog <= watchdog + 8'd1;
      end
      if (state == S_WAIT && alu_done) begin
        last_alu_result <= alu_result;
      end
      if (wd_expire) begin
        err <= 1'b1;
      end
      if (en_pc) begin
        instr_count <= instr_count + 16'd1;
      end
    end
  end

endmodule
